// File: rtl/sram_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_req_arbiter_if
//  Description : sram-like request/response bus (address phase + data phase).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_req_arbiter
//  Description : Shares one sram-like port between fetch and load/store
//                masters; in-order owner FIFO routes responses back.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_req_arbiter #(
    parameter int MAX_OUTS   = 2,
    parameter int STARVE_LIM = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    sram_req_arbiter_if.slave   inst_bus,
    sram_req_arbiter_if.slave   data_bus,
    sram_req_arbiter_if.master  mem_bus,
    output logic                err_spurious
);

    localparam int PTR_W = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam int DEPTH = 1 << PTR_W;
    localparam int CNT_W = $clog2(MAX_OUTS + 1);
    localparam int SC_W  = $clog2(STARVE_LIM + 1);

    localparam logic [PTR_W-1:0] c_PTR_LAST  = PTR_W'(MAX_OUTS - 1);
    localparam logic [CNT_W-1:0] c_CNT_FULL  = CNT_W'(MAX_OUTS);
    localparam logic [SC_W-1:0]  c_STARVE_MX = SC_W'(STARVE_LIM);

    logic [DEPTH-1:0] r_owner;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_outs_cnt;
    logic [SC_W-1:0]  r_starve_cnt;
    logic             r_err_spurious;

    logic w_full;
    logic w_empty;
    logic w_inst_forced;
    logic w_grant_data;
    logic w_grant_inst;
    logic w_push;
    logic w_pop;
    logic w_spurious;
    logic w_head_data;
    logic w_resp_inst;
    logic w_resp_data;

    assign w_full  = (r_outs_cnt == c_CNT_FULL);
    assign w_empty = (r_outs_cnt == '0);

    // Grants are forced low during reset so every output is quiet while it is held.
    assign w_inst_forced = inst_bus.req && (r_starve_cnt == c_STARVE_MX);
    assign w_grant_data  = !reset && !w_full && data_bus.req && !w_inst_forced;
    assign w_grant_inst  = !reset && !w_full && inst_bus.req && !w_grant_data;

    assign mem_bus.req   = w_grant_data || w_grant_inst;
    assign mem_bus.wr    = w_grant_data ? data_bus.wr    : 1'b0;
    assign mem_bus.size  = w_grant_data ? data_bus.size  : (w_grant_inst ? 2'd2 : 2'd0);
    assign mem_bus.wstrb = w_grant_data ? data_bus.wstrb : 4'h0;
    assign mem_bus.wdata = w_grant_data ? data_bus.wdata : 32'h0;
    assign mem_bus.addr  = w_grant_data ? data_bus.addr
                         : (w_grant_inst ? inst_bus.addr : 32'h0);

    assign data_bus.addr_ok = w_grant_data && mem_bus.addr_ok;
    assign inst_bus.addr_ok = w_grant_inst && mem_bus.addr_ok;

    assign w_push     = mem_bus.req && mem_bus.addr_ok;
    assign w_pop      = mem_bus.data_ok && !w_empty;
    assign w_spurious = mem_bus.data_ok && w_empty;

    assign w_head_data = r_owner[r_rd_ptr];
    assign w_resp_inst = !reset && w_pop && !w_head_data;
    assign w_resp_data = !reset && w_pop &&  w_head_data;

    assign inst_bus.data_ok = w_resp_inst;
    assign inst_bus.rdata   = w_resp_inst ? mem_bus.rdata : 32'h0;
    assign data_bus.data_ok = w_resp_data;
    assign data_bus.rdata   = w_resp_data ? mem_bus.rdata : 32'h0;

    assign err_spurious = r_err_spurious;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner        <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_outs_cnt     <= '0;
            r_starve_cnt   <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            if (w_push) begin
                r_owner[r_wr_ptr] <= w_grant_data;
                r_wr_ptr          <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end

            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_outs_cnt <= r_outs_cnt + 1'b1;
                2'b01:   r_outs_cnt <= r_outs_cnt - 1'b1;
                default: r_outs_cnt <= r_outs_cnt;
            endcase

            if (!inst_bus.req || (w_grant_inst && w_push)) begin
                r_starve_cnt <= '0;
            end else if (w_grant_data && w_push && (r_starve_cnt != c_STARVE_MX)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            if (w_spurious) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_req_arbiter
//  Description : Directed self-checking bench for sram_req_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_req_arbiter;

    logic clk;
    logic reset;
    logic err_spurious;

    int total;
    int bad;

    sram_req_arbiter_if inst_bus ();
    sram_req_arbiter_if data_bus ();
    sram_req_arbiter_if mem_bus ();

    sram_req_arbiter #(
        .MAX_OUTS   (2),
        .STARVE_LIM (4)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .inst_bus     (inst_bus),
        .data_bus     (data_bus),
        .mem_bus      (mem_bus),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fields the arbiter drives on the master side of the memory bus and
    // on the slave side of the two master buses are left to the DUT.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        reset          = 1'b1;
        inst_bus.req   = 1'b1;
        inst_bus.wr    = 1'b1;
        inst_bus.size  = 2'd0;
        inst_bus.wstrb = 4'hf;
        inst_bus.addr  = 32'h0000_0100;
        inst_bus.wdata = 32'hffff_ffff;
        data_bus.req   = 1'b0;
        data_bus.wr    = 1'b0;
        data_bus.size  = 2'd2;
        data_bus.wstrb = 4'h0;
        data_bus.addr  = 32'h0000_2000;
        data_bus.wdata = 32'h0;
        mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b0;
        mem_bus.rdata   = 32'h0;

        // Reset held two cycles with a fetch pending.
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            chk("rst_m_req",   32'(mem_bus.req),      32'd0);
            chk("rst_iaok",    32'(inst_bus.addr_ok), 32'd0);
            chk("rst_m_addr",  mem_bus.addr,          32'h0);
            chk("rst_err",     32'(err_spurious),     32'd0);
        end
        step(); reset = 1'b0; #1;
        chk("post_rst_m_req",  32'(mem_bus.req),  32'd1);
        chk("post_rst_m_addr", mem_bus.addr,      32'h0000_0100);
        chk("post_rst_m_wr",   32'(mem_bus.wr),   32'd0);
        chk("post_rst_m_size", 32'(mem_bus.size), 32'd2);
        chk("post_rst_m_strb", 32'(mem_bus.wstrb),32'd0);
        chk("post_rst_iaok",   32'(inst_bus.addr_ok), 32'd0);

        // One idle cycle with inst_req low clears the starvation count.
        step(); inst_bus.req = 1'b0; #1;
        chk("idle_m_req", 32'(mem_bus.req), 32'd0);

        // Contention: data wins 4 times, inst forced on 5th, data again on 6th.
        for (int k = 1; k <= 6; k++) begin
            step();
            inst_bus.req    = 1'b1;
            data_bus.req    = 1'b1;
            mem_bus.addr_ok = 1'b1;
            mem_bus.data_ok = (k > 1);
            mem_bus.rdata   = 32'ha000_0000 + 32'(k);
            #1;
            chk($sformatf("starve_daok_%0d", k), 32'(data_bus.addr_ok), 32'(k != 5));
            chk($sformatf("starve_iaok_%0d", k), 32'(inst_bus.addr_ok), 32'(k == 5));
            chk($sformatf("starve_maddr_%0d", k), mem_bus.addr,
                (k == 5) ? 32'h0000_0100 : 32'h0000_2000);
            chk($sformatf("starve_ddok_%0d", k), 32'(data_bus.data_ok), 32'(k >= 2 && k != 6));
            chk($sformatf("starve_idok_%0d", k), 32'(inst_bus.data_ok), 32'(k == 6));
            if (k == 6)
                chk("starve_irdata", inst_bus.rdata, 32'ha000_0006);
        end
        step();
        inst_bus.req    = 1'b0;
        data_bus.req    = 1'b0;
        mem_bus.data_ok = 1'b1;
        mem_bus.rdata   = 32'h1234_5678;
        #1;
        chk("tail_ddok",   32'(data_bus.data_ok), 32'd1);
        chk("tail_drdata", data_bus.rdata,        32'h1234_5678);
        chk("tail_idok",   32'(inst_bus.data_ok), 32'd0);

        // Fill to MAX_OUTS with no responses, then stall.
        step();
        data_bus.req    = 1'b1;
        data_bus.addr   = 32'h0000_3000;
        mem_bus.data_ok = 1'b0;
        #1;
        chk("fill1_aok", 32'(data_bus.addr_ok), 32'd1);
        step(); #1;
        chk("fill2_aok", 32'(data_bus.addr_ok), 32'd1);
        step(); #1;
        chk("full_m_req", 32'(mem_bus.req),      32'd0);
        chk("full_aok",   32'(data_bus.addr_ok), 32'd0);

        // Full with a response: pop but no push this cycle, accept the next.
        step(); mem_bus.data_ok = 1'b1; #1;
        chk("fullpop_m_req", 32'(mem_bus.req),      32'd0);
        chk("fullpop_ddok",  32'(data_bus.data_ok), 32'd1);
        step(); mem_bus.data_ok = 1'b0; #1;
        chk("refill_m_req", 32'(mem_bus.req),      32'd1);
        chk("refill_aok",   32'(data_bus.addr_ok), 32'd1);
        step(); data_bus.req = 1'b0; mem_bus.data_ok = 1'b1; #1;
        chk("drain1_ddok", 32'(data_bus.data_ok), 32'd1);
        step(); #1;
        chk("drain2_ddok", 32'(data_bus.data_ok), 32'd1);
        chk("drain2_err",  32'(err_spurious),     32'd0);

        // FIFO now empty: a further response is spurious.
        step(); #1;
        chk("spur_ddok", 32'(data_bus.data_ok), 32'd0);
        chk("spur_idok", 32'(inst_bus.data_ok), 32'd0);
        step(); mem_bus.data_ok = 1'b0; #1;
        chk("spur_err1", 32'(err_spurious), 32'd1);
        step(); #1;
        chk("spur_err2", 32'(err_spurious), 32'd1);

        // Store fields pass straight through.
        step();
        data_bus.req   = 1'b1;
        data_bus.wr    = 1'b1;
        data_bus.size  = 2'd1;
        data_bus.wstrb = 4'b0011;
        data_bus.addr  = 32'h1c00_0004;
        data_bus.wdata = 32'hdead_beef;
        #1;
        chk("st_m_req",   32'(mem_bus.req),      32'd1);
        chk("st_m_wr",    32'(mem_bus.wr),       32'd1);
        chk("st_m_size",  32'(mem_bus.size),     32'd1);
        chk("st_m_wstrb", 32'(mem_bus.wstrb),    32'h3);
        chk("st_m_addr",  mem_bus.addr,          32'h1c00_0004);
        chk("st_m_wdata", mem_bus.wdata,         32'hdead_beef);
        chk("st_aok",     32'(data_bus.addr_ok), 32'd1);
        step(); data_bus.req = 1'b0; mem_bus.data_ok = 1'b1; #1;
        chk("st_ddok", 32'(data_bus.data_ok), 32'd1);
        chk("st_idok", 32'(inst_bus.data_ok), 32'd0);

        // Only reset clears the sticky error.
        step(); mem_bus.data_ok = 1'b0; reset = 1'b1; #1;
        chk("pre_rst_err", 32'(err_spurious), 32'd1);
        step(); reset = 1'b0; #1;
        chk("clr_err", 32'(err_spurious), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
